// File: rtl/b16_io_pkg.sv
// b16_io_pkg: shared address offsets and STAT bit positions for the b16 UART I/O port
package b16_io_pkg;
  typedef enum logic [1:0] {
    ADDR_DATA = 2'b00,
    ADDR_STAT = 2'b10
  } addr_e;
  localparam int ST_RXNE  = 15;
  localparam int ST_TXNF  = 14;
  localparam int ST_RXOVF = 13;
  localparam int ST_TXOVF = 12;
  localparam int ST_IE    = 11;
  localparam int ST_TXCNT = 5;
  localparam int ST_RXCNT = 0;
endpackage

// File: rtl/b16_fifo.sv
// b16_fifo: first-word-fall-through byte FIFO; a pop frees a slot for a same-cycle push when full
module b16_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_nreset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_din,
  output logic [7:0]    o_dout,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_pop;
  logic          w_push;
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & !o_empty;
  assign w_push  = i_push & (!o_full | w_pop);
  assign o_dout  = o_empty ? 8'h00 : r_mem[r_rp];
  // storage needs no reset: emptiness is tracked by the count alone
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp] <= i_din;
  // pointers wrap naturally at DEPTH; count moves only on an unmatched push or pop
  always_ff @(posedge i_clk or negedge i_nreset)
    if (!i_nreset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
endmodule

// File: rtl/b16_uart_io.sv
// b16_uart_io: memory-mapped UART port at 0xFFFC-0xFFFF with TX/RX FIFOs; B16IO_IRQ_EN adds ie and a registered irq
module b16_uart_io
  import b16_io_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        i_clk,
  input  logic        i_nreset,
  input  logic        i_cs,
  input  logic        i_en,
  input  logic        i_a1,
  input  logic        i_r,
  input  logic [1:0]  i_w,
  input  logic [15:0] i_dwrite,
  output logic [15:0] o_rdata,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_strobe,
  output logic        o_irq
);
  addr_e       w_off;
  logic        w_bus_wr;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic        w_rx_pop;
  logic        w_stat_wr;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic [AW:0] w_tx_cnt;
  logic [AW:0] w_rx_cnt;
  logic [7:0]  w_rx_dout;
  logic        w_ie;
  logic [15:0] w_stat;
  logic        w_unused;
  logic        r_rx_ovf;
  logic        r_tx_ovf;
  assign w_off      = i_a1 ? ADDR_STAT : ADDR_DATA;
  assign w_bus_wr   = i_cs & !i_r & i_en;
  assign w_tx_push  = w_bus_wr & (w_off == ADDR_DATA) & i_w[0];
  assign w_stat_wr  = w_bus_wr & (w_off == ADDR_STAT) & i_w[1];
  assign w_rx_pop   = i_cs & i_r & i_en & (w_off == ADDR_DATA);
  assign o_tx_valid = !w_tx_empty;
  assign w_tx_pop   = o_tx_valid & i_tx_ready;
  assign w_unused   = ^i_dwrite[15:8];
  b16_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx (
    .i_clk    (i_clk),
    .i_nreset (i_nreset),
    .i_push   (w_tx_push),
    .i_pop    (w_tx_pop),
    .i_din    (i_dwrite[7:0]),
    .o_dout   (o_tx_data),
    .o_count  (w_tx_cnt),
    .o_full   (w_tx_full),
    .o_empty  (w_tx_empty)
  );
  b16_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx (
    .i_clk    (i_clk),
    .i_nreset (i_nreset),
    .i_push   (i_rx_strobe),
    .i_pop    (w_rx_pop),
    .i_din    (i_rx_data),
    .o_dout   (w_rx_dout),
    .o_count  (w_rx_cnt),
    .o_full   (w_rx_full),
    .o_empty  (w_rx_empty)
  );
  // sticky overflow flags: a drop only counts when no same-cycle pop made room; set beats clear
  always_ff @(posedge i_clk or negedge i_nreset)
    if (!i_nreset) begin
      r_rx_ovf <= 1'b0;
      r_tx_ovf <= 1'b0;
    end else begin
      r_rx_ovf <= (i_rx_strobe & w_rx_full & !w_rx_pop) | (r_rx_ovf & !(w_stat_wr & i_dwrite[ST_RXOVF]));
      r_tx_ovf <= (w_tx_push & w_tx_full & !w_tx_pop) | (r_tx_ovf & !(w_stat_wr & i_dwrite[ST_TXOVF]));
    end
`ifdef B16IO_IRQ_EN
  logic r_ie;
  logic r_irq;
  // interrupt enable and registered request, one clock behind the FIFO/flag state
  always_ff @(posedge i_clk or negedge i_nreset)
    if (!i_nreset) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_stat_wr) r_ie <= i_dwrite[ST_IE];
      r_irq <= r_ie & (!w_rx_empty | r_rx_ovf);
    end
  assign w_ie  = r_ie;
  assign o_irq = r_irq;
`else
  assign w_ie  = 1'b0;
  assign o_irq = 1'b0;
`endif
  // STAT assembly and zero-wait-state read mux; bus floats to 0 when not reading the window
  always_comb begin
    w_stat                     = '0;
    w_stat[ST_RXNE]            = !w_rx_empty;
    w_stat[ST_TXNF]            = !w_tx_full;
    w_stat[ST_RXOVF]           = r_rx_ovf;
    w_stat[ST_TXOVF]           = r_tx_ovf;
    w_stat[ST_IE]              = w_ie;
    w_stat[ST_TXCNT +: AW+1]   = w_tx_cnt;
    w_stat[ST_RXCNT +: AW+1]   = w_rx_cnt;
    o_rdata = !(i_cs & i_r) ? 16'h0000 : (w_off == ADDR_STAT) ? w_stat : {!w_rx_empty, 7'b0, w_rx_dout};
  end
endmodule
